// File: rtl/l1_arb_pkg.sv
// l1_arb_pkg: shared types and constants for the L1 read-port arbiter.
//   state_e  - arbiter sequencing states
//   owner_e  - which requester owns the in-flight request
//   L1_ADDR_W / L1_DATA_W - default cache address / data widths
//   L1_NOP_INSN - instruction word fetch substitutes when a response is an error
package l1_arb_pkg;

  localparam int unsigned L1_ADDR_W = 16;
  localparam int unsigned L1_DATA_W = 32;

  localparam logic [31:0] L1_NOP_INSN = {6'b111111, 26'd0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/l1_arb_rr2.sv
// l1_arb_rr2: two-input arbiter between fetch (F) and data (D).
//   clk, rst_n       - clock, asynchronous active-low reset
//   f_valid, d_valid - requests from F and D
//   en               - arbitration is open this cycle (parent is idle)
//   grant_f, grant_d - combinational one-hot (or zero) grant
//   accept           - a grant is being taken on this edge
// The last_grant register starts at D so F wins the first tie after reset.
module l1_arb_rr2
  import l1_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic f_valid,
  input  logic d_valid,
  input  logic en,
  output logic grant_f,
  output logic grant_d,
  output logic accept
);

  owner_e last_grant_q, last_grant_d;

  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (f_valid && d_valid) begin
      // Tie: fixed priority favours F, otherwise the one not served last.
      if (FIXED_PRIO || (last_grant_q == OWN_D)) begin
        grant_f = 1'b1;
      end else begin
        grant_d = 1'b1;
      end
    end else begin
      grant_f = f_valid;
      grant_d = d_valid;
    end

    accept       = en && (f_valid || d_valid);
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = grant_f ? OWN_F : OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWN_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/l1_port_arbiter.sv
// l1_port_arbiter: shares the L1 cache read port between fetch (F) and data (D).
//   clk, rst_n                      - clock, asynchronous active-low reset
//   f_req_valid/ready/addr          - fetch request handshake
//   f_rsp_valid/data/err            - fetch response (one-cycle pulse, no backpressure)
//   d_req_* / d_rsp_*               - same for the data port
//   cache_en, cache_addr            - cache clock-enable and read address
//   cache_data, cache_ready         - cache read data and data-ready flag
//   busy                            - arbiter is not idle
// Sequence: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. WAIT gives up after
// TIMEOUT cycles without cache_ready and returns data 0 with err set.
module l1_port_arbiter
  import l1_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = L1_ADDR_W,
  parameter int unsigned DATA_W     = L1_DATA_W,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  output logic              f_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              d_rsp_err,
  output logic              cache_en,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic [DATA_W-1:0] cache_data,
  input  logic              cache_ready,
  output logic              busy
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] f_data_q, f_data_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;

  logic grant_f, grant_d, accept;
  logic idle;

  assign idle = (state_q == IDLE);

  l1_arb_rr2 #(
    .FIXED_PRIO(FIXED_PRIO != 0)
  ) u_rr2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .f_valid (f_req_valid),
    .d_valid (d_req_valid),
    .en      (idle),
    .grant_f (grant_f),
    .grant_d (grant_d),
    .accept  (accept)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    f_data_d = f_data_q;
    d_data_d = d_data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant_f ? OWN_F : OWN_D;
          addr_d  = grant_f ? f_req_addr : d_req_addr;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Response data goes straight into the owner's output register so
        // the other port's data output keeps its last value.
        if (cache_ready) begin
          err_d   = 1'b0;
          state_d = RESP;
          if (owner_q == OWN_F) f_data_d = cache_data;
          else                  d_data_d = cache_data;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
          if (owner_q == OWN_F) f_data_d = '0;
          else                  d_data_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_F;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      f_data_q <= '0;
      d_data_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      f_data_q <= f_data_d;
      d_data_q <= d_data_d;
    end
  end

  assign f_req_ready = idle && grant_f;
  assign d_req_ready = idle && grant_d;

  assign cache_en   = (state_q == ISSUE) || (state_q == WAIT);
  assign cache_addr = addr_q;
  assign busy       = !idle;

  assign f_rsp_valid = (state_q == RESP) && (owner_q == OWN_F);
  assign d_rsp_valid = (state_q == RESP) && (owner_q == OWN_D);
  assign f_rsp_err   = f_rsp_valid && err_q;
  assign d_rsp_err   = d_rsp_valid && err_q;
  assign f_rsp_data  = f_data_q;
  assign d_rsp_data  = d_data_q;

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Bench for l1_port_arbiter: two instances (round-robin and fixed priority)
// driven with shared requests and per-instance cache behaviour, checked every
// cycle against a transaction-level reference model.
module tb_l1_port_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        f_v, d_v;
  logic [15:0] f_a, d_a;
  logic [1:0]  f_rdy, d_rdy, f_rv, d_rv, f_re, d_re, c_en, c_rdy, bsy;
  logic [31:0] f_rd [2];
  logic [31:0] d_rd [2];
  logic [31:0] c_data [2];
  logic [15:0] c_addr [2];

  function automatic logic [31:0] mem(input logic [15:0] a);
    return {a ^ 16'hC35A, ~a};
  endfunction

  assign c_data[0] = mem(c_addr[0]);
  assign c_data[1] = mem(c_addr[1]);

  l1_port_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO), .FIXED_PRIO(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_v), .f_req_ready(f_rdy[0]), .f_req_addr(f_a),
    .f_rsp_valid(f_rv[0]), .f_rsp_data(f_rd[0]), .f_rsp_err(f_re[0]),
    .d_req_valid(d_v), .d_req_ready(d_rdy[0]), .d_req_addr(d_a),
    .d_rsp_valid(d_rv[0]), .d_rsp_data(d_rd[0]), .d_rsp_err(d_re[0]),
    .cache_en(c_en[0]), .cache_addr(c_addr[0]), .cache_data(c_data[0]),
    .cache_ready(c_rdy[0]), .busy(bsy[0]));

  l1_port_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO), .FIXED_PRIO(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_v), .f_req_ready(f_rdy[1]), .f_req_addr(f_a),
    .f_rsp_valid(f_rv[1]), .f_rsp_data(f_rd[1]), .f_rsp_err(f_re[1]),
    .d_req_valid(d_v), .d_req_ready(d_rdy[1]), .d_req_addr(d_a),
    .d_rsp_valid(d_rv[1]), .d_rsp_data(d_rd[1]), .d_rsp_err(d_re[1]),
    .cache_en(c_en[1]), .cache_addr(c_addr[1]), .cache_data(c_data[1]),
    .cache_ready(c_rdy[1]), .busy(bsy[1]));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model, one transaction record per instance.
  // age: cycles since acceptance (1 = address issue cycle, >=2 = waiting).
  // waited: waiting cycles already spent without cache_ready.
  bit          m_busy [2];
  bit          m_own  [2];   // 0 = F, 1 = D
  logic [15:0] m_addr [2];
  int          m_age  [2];
  int          m_wait [2];
  bit          m_resp [2];
  bit          m_err  [2];
  logic [31:0] m_fd   [2];
  logic [31:0] m_dd   [2];
  bit          m_last [2];   // last requester served, 0 = F, 1 = D

  int rq_mode, cm_mode;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_own[i] = 0; m_addr[i] = '0; m_age[i] = 0;
      m_wait[i] = 0; m_resp[i] = 0; m_err[i] = 0;
      m_fd[i] = '0; m_dd[i] = '0; m_last[i] = 1;
    end
  endtask

  task automatic model_grant(input int i, output bit gf, output bit gd);
    gf = 0; gd = 0;
    if (!m_busy[i]) begin
      if (f_v && d_v) begin
        if (i == 1 || m_last[i]) gf = 1;
        else                     gd = 1;
      end else begin
        gf = f_v; gd = d_v;
      end
    end
  endtask

  task automatic drive();
    case (rq_mode)
      0: begin f_v = $urandom_range(1, 0) != 0; d_v = $urandom_range(1, 0) != 0; end
      1: begin f_v = 1; d_v = 1; end
      2: begin f_v = 1; d_v = 0; end
      3: begin f_v = 0; d_v = 1; end
      default: begin f_v = 0; d_v = 0; end
    endcase
    f_a = (rq_mode == 2) ? 16'h000A : 16'($urandom);
    d_a = 16'($urandom);
    for (int i = 0; i < 2; i++) begin
      case (cm_mode)
        0: c_rdy[i] = ($urandom_range(3, 0) == 0);
        1: c_rdy[i] = 1'b0;
        2: c_rdy[i] = m_busy[i] && !m_resp[i] && m_age[i] >= 2 && m_wait[i] == TO - 1;
        default: c_rdy[i] = 1'b1;
      endcase
    end
  endtask

  task automatic check_all();
    bit gf, gd, en, fv, dv;
    for (int i = 0; i < 2; i++) begin
      model_grant(i, gf, gd);
      en = m_busy[i] && !m_resp[i];
      fv = m_busy[i] && m_resp[i] && !m_own[i];
      dv = m_busy[i] && m_resp[i] && m_own[i];
      check($sformatf("u%0d.f_req_ready", i), f_rdy[i], gf);
      check($sformatf("u%0d.d_req_ready", i), d_rdy[i], gd);
      check($sformatf("u%0d.cache_en", i), c_en[i], en);
      if (en) check($sformatf("u%0d.cache_addr", i), c_addr[i], m_addr[i]);
      check($sformatf("u%0d.busy", i), bsy[i], m_busy[i]);
      check($sformatf("u%0d.f_rsp_valid", i), f_rv[i], fv);
      check($sformatf("u%0d.d_rsp_valid", i), d_rv[i], dv);
      check($sformatf("u%0d.f_rsp_err", i), f_re[i], fv && m_err[i]);
      check($sformatf("u%0d.d_rsp_err", i), d_re[i], dv && m_err[i]);
      check($sformatf("u%0d.f_rsp_data", i), f_rd[i], m_fd[i]);
      check($sformatf("u%0d.d_rsp_data", i), d_rd[i], m_dd[i]);
    end
  endtask

  task automatic model_step();
    bit gf, gd;
    for (int i = 0; i < 2; i++) begin
      model_grant(i, gf, gd);
      if (!m_busy[i]) begin
        if (gf || gd) begin
          m_busy[i] = 1; m_own[i] = gd; m_last[i] = gd;
          m_addr[i] = gf ? f_a : d_a;
          m_age[i] = 1; m_wait[i] = 0; m_resp[i] = 0;
        end
      end else if (m_resp[i]) begin
        m_busy[i] = 0;
      end else if (m_age[i] == 1) begin
        m_age[i] = 2;
      end else if (c_rdy[i]) begin
        m_resp[i] = 1; m_err[i] = 0;
        if (m_own[i]) m_dd[i] = mem(m_addr[i]); else m_fd[i] = mem(m_addr[i]);
      end else if (m_wait[i] == TO - 1) begin
        m_resp[i] = 1; m_err[i] = 1;
        if (m_own[i]) m_dd[i] = '0; else m_fd[i] = '0;
      end else begin
        m_wait[i]++;
      end
    end
  endtask

  task automatic run(input int rq, input int cm, input int n);
    rq_mode = rq;
    cm_mode = cm;
    repeat (n) begin
      drive();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2;
    f_v = 0; d_v = 0; c_rdy = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("u0.cache_addr_rst", c_addr[0], 16'h0);
    check("u1.cache_addr_rst", c_addr[1], 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    f_v = 0; d_v = 0; f_a = '0; d_a = '0; c_rdy = '0;
    model_reset();
    #1;
    check_all();
    check("u0.cache_addr_rst", c_addr[0], 16'h0);
    check("u1.cache_addr_rst", c_addr[1], 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(2, 3, 8);     // single F requests at 0x000A, immediate cache_ready
    run(4, 0, 2);
    run(1, 3, 40);    // both held: alternate (u0) vs F only (u1)
    run(3, 1, 40);    // D with no cache_ready: timeouts
    run(3, 2, 40);    // cache_ready exactly at the last wait cycle
    run(3, 3, 8);
    run(3, 1, 6);     // leave a request in the wait phase
    pulse_reset();
    run(1, 3, 16);    // first tie after reset goes to F
    run(0, 0, 400);
    run(1, 0, 200);
    for (int k = 0; k < 30; k++) begin
      run(int'($urandom_range(4, 0)), int'($urandom_range(3, 0)), int'($urandom_range(49, 10)));
    end
    run(1, 1, 20);
    pulse_reset();
    run(0, 2, 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/l1_port_arbiter.md
Name: l1_port_arbiter

Overview:
- Shares the single read port of the L1 cache between two requesters: instruction fetch (F) and data load (D).
- Accepts one request at a time over a valid/ready handshake and drives the cache address and clock-enable.
- Waits for the cache's data-ready flag, with a timeout, then returns the read data to the requester that issued it.
- Sits between the fetch/load-store units and the L1 cache; it is the only master of the cache's clock-enable and address inputs.

Parameters:
- ADDR_W, 16, request/cache address width
- DATA_W, 32, read data width
- TIMEOUT, 15, maximum WAIT cycles before an error response; range 1..255
- FIXED_PRIO, 0, 0 = round-robin between F and D; 1 = F always wins ties

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req_valid  in  1  fetch request valid
- f_req_ready  out  1  fetch request accepted this cycle
- f_req_addr  in  ADDR_W  fetch address
- f_rsp_valid  out  1  fetch response pulse
- f_rsp_data  out  DATA_W  fetch response data
- f_rsp_err  out  1  fetch response is a timeout error
- d_req_valid / d_req_ready / d_req_addr / d_rsp_valid / d_rsp_data / d_rsp_err: same as the f_ signals, for the data port
- cache_en  out  1  cache clock-enable
- cache_addr  out  ADDR_W  cache read address
- cache_data  in  DATA_W  cache read data
- cache_ready  in  1  cache data-ready flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE, owner=F, last_grant=D, so F wins the first tie.
  - Timeout counter, address register and response data registers are cleared.
  - All rsp_valid, rsp_err, cache_en and busy are 0; cache_addr is 0.
- Reset mid-operation: any in-flight request is dropped and no response is issued. The requester must re-request.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, grant logic (combinational):
  - Grant goes to the valid requester.
  - If both are valid: with FIXED_PRIO=1, F wins; with FIXED_PRIO=0, the requester not in last_grant wins.
  - x_req_ready = (state==IDLE) & grant_x. At most one ready is high per cycle.
  - On the accepting edge: latch addr and owner, update last_grant, clear the counter, go to ISSUE.
- ISSUE (1 cycle): cache_en=1, cache_addr=latched address, then go to WAIT.
- WAIT:
  - cache_en stays 1 and cache_addr is held.
  - If cache_ready=1: capture cache_data into the response register with err=0, go to RESP.
  - Otherwise the counter increments. When counter==TIMEOUT-1 and cache_ready is still 0: response data=0, err=1, go to RESP.
  - cache_ready takes precedence over timeout in the same cycle.
- RESP (1 cycle):
  - owner's rsp_valid=1, with rsp_data and rsp_err taken from the response register.
  - The other port's rsp_valid=0. There is no response backpressure.
  - Cache_en=0. Next state is IDLE.
- Response data outputs hold their last value outside RESP; rsp_err=0 outside RESP.
- Latency: handshake at edge T; cache_en high in cycles T+1 and T+2; with an immediate cache_ready, rsp_valid is high in T+3. Peak throughput is one request per 4 cycles.
- A requester may hold valid through its own response; it is re-arbitrated in the next IDLE.
- A requester that drops valid before ready is simply not granted.
- Address changes while a request is in flight have no effect.
- Counter width is 8 bits; it never wraps because it exits at TIMEOUT-1.

Decomposition:
- Package l1_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner enum {OWN_F, OWN_D}
  - constants L1_ADDR_W=16, L1_DATA_W=32
  - the no-op instruction constant {6'b111111, 26'd0}, for later use by fetch on err
- One sub-module, l1_arb_rr2: the two-input arbiter. It has combinational grant outputs plus the last_grant register, which updates on accept.

Test Plan:
- Single F request addr=0x000A, cache_ready=1 from T+2 -> f_req_ready at T, cache_en high T+1..T+2, f_rsp_valid at T+3 with data=cache word 10, err=0; d_rsp_valid stays 0.
- F and D held valid continuously, FIXED_PRIO=0 -> grants alternate F,D,F,D starting with F; each response goes to its owner only.
- Same stimulus with FIXED_PRIO=1 -> four consecutive grants to F; D gets no grant while F is valid.
- D request, cache_ready held 0, TIMEOUT=15 -> d_rsp_valid with err=1, data=0 after 15 WAIT cycles; next request is serviced normally.
- cache_ready rises on the same cycle the counter reaches TIMEOUT-1 -> err=0, data captured.
- rst_n pulsed low during WAIT -> all outputs 0 immediately (async); no rsp_valid afterwards; the first post-reset tie is granted to F.
